fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction-memory/I-cache reads for the fetch stage.
- Supplies the IF/ID-facing instruction register (instruction, PC+2, valid).
- Applies redirects from branch/jump resolution, including redirects that arrive while a cache miss is outstanding.
- Holds fetch under pipeline stall and stops fetching permanently on HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, value driven on instr_out whenever instr_valid=0

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (asserted when 0)
imem_rd  output  1  one-cycle read request pulse to instruction memory
imem_addr  output  16  fetch address; always equals internal pc
imem_done  input  1  read complete this cycle; imem_data valid
imem_stall  input  1  memory busy with miss (informational; the FSM keys on imem_done)
imem_data  input  16  instruction word, valid when imem_done=1
pipe_stall  input  1  decode cannot accept a new instruction this cycle
redirect  input  1  branch taken or jump resolved this cycle
redirect_pc  input  16  redirect target, valid with redirect
halt  input  1  HALT decoded on the correct path
instr_out  output  16  registered instruction to decode
pc_plus2_out  output  16  registered (fetch PC + 2) of instr_out, 16-bit wrap
instr_valid  output  1  instr_out is a real instruction
fetch_busy  output  1  miss outstanding (state WAIT)
halted  output  1  fetch permanently stopped

Behaviour:
- Reset (rst=0 at clock edge) has priority over everything:
  - pc=RESET_PC; state=REQ; pend_valid=0.
  - instr_valid=0, instr_out=NOP_INSTR, pc_plus2_out=0, halted=0.
  - imem_rd=0 in the cycle after reset.
  - Reset mid-miss abandons the miss; a stale imem_done arriving in REQ with imem_rd=0 is ignored.
- Priority among other events: redirect > halt > normal sequencing.
- States: REQ, WAIT, HOLD, HALTED.
- REQ:
  - imem_rd = !pipe_stall & !redirect.
  - imem_rd=1 and imem_done=1 (hit, same cycle): instruction fetched; pc<=pc+2; stay REQ.
  - imem_rd=1 and imem_done=0: go WAIT.
  - redirect: pc<=redirect_pc, no request issued, stay REQ.
- WAIT:
  - imem_rd=0. imem_addr held stable (pc is not modified in WAIT).
  - Redirect in WAIT: pend_valid<=1, pend_pc<=redirect_pc. A later redirect overwrites pend_pc. IR flushed.
  - On imem_done with pend_valid=1 or redirect this cycle: data discarded; pc<=latest target; pend_valid<=0; go REQ.
  - On imem_done otherwise: pc<=pc+2. If pipe_stall=0, data goes to IR and state goes REQ. If pipe_stall=1, data goes to hold buffer (hold_instr, hold_pc2) and state goes HOLD.
- HOLD:
  - imem_rd=0.
  - When pipe_stall=0: IR<=hold buffer; go REQ.
  - Redirect: buffer discarded; pc<=redirect_pc; go REQ.
- IR update each edge:
  - redirect: instr_valid<=0, instr_out<=NOP_INSTR.
  - else if !pipe_stall: instr_valid<=fetched_this_cycle; instr_out/pc_plus2_out loaded with the fetched data and its pc+2, or NOP_INSTR/unchanged when instr_valid<=0.
  - else (pipe_stall): IR holds all values.
- Latency: on a hit, instruction visible on instr_out one cycle after imem_rd. On a miss, one cycle after imem_done.
- Halt:
  - halt=1 with no redirect and no miss outstanding (REQ/HOLD): go HALTED next edge. Any HOLD buffer is discarded.
  - halt in WAIT: set halt_pend. On imem_done, discard data and go HALTED.
  - HALTED: imem_rd=0, instr_valid=0, halted=1; left only by reset. Redirect in HALTED is ignored.
  - Redirect in the same cycle as halt: halt ignored (wrong-path HALT).
- pc arithmetic: unsigned 16-bit, wraps; 16'hFFFE+2=16'h0000. redirect_pc is used as given (no alignment check).
- fetch_busy=1 exactly when state=WAIT.

Test Plan:
1. Reset with RESET_PC=0; memory always hits with imem_data=addr^16'hA5A5. Expected: imem_addr=0,2,4 on consecutive cycles; instr_out=16'hA5A5,16'hA5A7,16'hA5A1; pc_plus2_out=2,4,6; instr_valid held 1.
2. Miss at 0x0010 with imem_done returning 4 cycles later. Expected: imem_rd pulses once; fetch_busy=1 for 4 cycles; imem_addr stays 0x0010; the instruction appears the cycle after done with pc_plus2_out=0x0012.
3. Redirect to 0x0100 two cycles into a miss at 0x0020. Expected: instr_valid drops next cycle; the returning data is discarded; the next imem_rd carries imem_addr=0x0100.
4. pipe_stall held 3 cycles while a miss completes. Expected: state HOLD; the IR keeps its old value; when the stall drops, the held instruction appears one cycle later; no extra imem_rd is issued while stalled.
5. halt during a miss. Expected: the miss completes and its data is discarded; halted=1 the next cycle; no further imem_rd over 20 cycles. Then rst=0 for one edge. Expected: fetching resumes at RESET_PC.
6. PC at 16'hFFFE on a hit. Expected: pc_plus2_out=16'h0000 and the next imem_addr=16'h0000. Redirect and halt in the same cycle. Expected: the redirect is taken and halted stays 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, issues instruction-memory reads and
// presents the fetched instruction (with its PC+2) to decode.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic        imem_done,
    input  logic        imem_stall,
    input  logic [15:0] imem_data,
    input  logic        pipe_stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        halted
);

    // Memory handshake: imem_rd is a one-cycle request for imem_addr; the read
    // completes in the first cycle imem_done=1 (same cycle = hit), and
    // imem_data is only meaningful in that cycle. Decode takes the IR on any
    // edge where pipe_stall=0.
    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD, ST_HALTED} state_t;

    state_t      state, state_next;
    logic [15:0] pc, pc_next, pc_plus2;
    logic        pend_valid, pend_valid_next;
    logic [15:0] pend_pc, pend_pc_next;
    logic        halt_pend, halt_pend_next;
    logic [15:0] hold_instr, hold_pc2;
    logic        hold_load;
    logic        fetched;
    logic [15:0] fetch_instr, fetch_pc2;
    logic        rd_enable;

    // The miss indication is informational only; completion is keyed on imem_done.
    logic unused_imem_stall;
    assign unused_imem_stall = imem_stall;

    assign pc_plus2   = pc + 16'd2;
    assign imem_addr  = pc;
    assign fetch_busy = (state == ST_WAIT);
    assign halted     = (state == ST_HALTED);

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pend_valid_next = pend_valid;
        pend_pc_next    = pend_pc;
        halt_pend_next  = halt_pend;
        hold_load       = 1'b0;
        fetched         = 1'b0;
        fetch_instr     = imem_data;
        fetch_pc2       = pc_plus2;
        imem_rd         = 1'b0;
        case (state)
            ST_REQ: begin
                imem_rd = rd_enable & ~pipe_stall & ~redirect & ~halt;
                if (redirect) begin
                    pc_next = redirect_pc;
                end else if (halt) begin
                    state_next = ST_HALTED;
                end else if (imem_rd) begin
                    if (imem_done) begin
                        fetched = 1'b1;
                        pc_next = pc_plus2;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A redirect after a halt proves the halt was on the wrong path.
                if (redirect) begin
                    pend_valid_next = 1'b1;
                    pend_pc_next    = redirect_pc;
                    halt_pend_next  = 1'b0;
                end else if (halt) begin
                    halt_pend_next = 1'b1;
                end
                if (imem_done) begin
                    pend_valid_next = 1'b0;
                    halt_pend_next  = 1'b0;
                    if (redirect) begin
                        pc_next    = redirect_pc;
                        state_next = ST_REQ;
                    end else if (halt_pend || halt) begin
                        state_next = ST_HALTED;
                    end else if (pend_valid) begin
                        pc_next    = pend_pc;
                        state_next = ST_REQ;
                    end else begin
                        pc_next = pc_plus2;
                        if (!pipe_stall) begin
                            fetched    = 1'b1;
                            state_next = ST_REQ;
                        end else begin
                            hold_load  = 1'b1;
                            state_next = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                fetch_instr = hold_instr;
                fetch_pc2   = hold_pc2;
                if (redirect) begin
                    pc_next    = redirect_pc;
                    state_next = ST_REQ;
                end else if (halt) begin
                    state_next = ST_HALTED;
                end else if (!pipe_stall) begin
                    fetched    = 1'b1;
                    state_next = ST_REQ;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= 16'h0000;
            halt_pend  <= 1'b0;
            hold_instr <= 16'h0000;
            hold_pc2   <= 16'h0000;
            rd_enable  <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pend_valid <= pend_valid_next;
            pend_pc    <= pend_pc_next;
            halt_pend  <= halt_pend_next;
            rd_enable  <= 1'b1;
            if (hold_load) begin
                hold_instr <= imem_data;
                hold_pc2   <= pc_plus2;
            end
        end
    end

    // Entering or sitting in HALTED clears the IR even if decode is stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_valid  <= 1'b0;
            instr_out    <= NOP_INSTR;
            pc_plus2_out <= 16'h0000;
        end else if (state_next == ST_HALTED || redirect) begin
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
        end else if (!pipe_stall) begin
            instr_valid <= fetched;
            if (fetched) begin
                instr_out    <= fetch_instr;
                pc_plus2_out <= fetch_pc2;
            end else begin
                instr_out <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hits, misses, redirects, stalls, halt, PC wrap.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_done;
    logic        imem_stall;
    logic [15:0] imem_data;
    logic        pipe_stall = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic [15:0] instr_out;
    logic [15:0] pc_plus2_out;
    logic        instr_valid;
    logic        fetch_busy;
    logic        halted;

    // Memory: hit_mode answers every request in the same cycle with addr^A5A5.
    logic        hit_mode = 1'b1;
    logic        man_done = 1'b0;
    logic [15:0] man_data = 16'h0000;
    assign imem_done  = hit_mode ? imem_rd : man_done;
    assign imem_data  = hit_mode ? (imem_addr ^ 16'hA5A5) : man_data;
    assign imem_stall = fetch_busy;

    int checks = 0;
    int failures = 0;
    int rd_cnt;
    int busy_cnt;
    int halt_cnt;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk(clk), .rst(rst), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_done(imem_done), .imem_stall(imem_stall), .imem_data(imem_data),
        .pipe_stall(pipe_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .instr_out(instr_out), .pc_plus2_out(pc_plus2_out),
        .instr_valid(instr_valid), .fetch_busy(fetch_busy), .halted(halted)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [15:0] a);
        redirect = 1'b1;
        redirect_pc = a;
        tick();
        redirect = 1'b0;
    endtask

    task automatic test_reset_and_hits;
        hit_mode = 1'b1; pipe_stall = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", imem_rd); end
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
        checks++; if (instr_valid !== 1'b0 || instr_out !== 16'h0800) begin failures++; $display("FAIL reset_ir got=%b/%h exp=0/0800", instr_valid, instr_out); end
        checks++; if (pc_plus2_out !== 16'h0000 || halted !== 1'b0 || fetch_busy !== 1'b0) begin failures++; $display("FAIL reset_misc got=%h/%b/%b exp=0000/0/0", pc_plus2_out, halted, fetch_busy); end
        tick();
        #1;
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin failures++; $display("FAIL hit_first_req got=%b/%h exp=1/0000", imem_rd, imem_addr); end
        tick();
        checks++; if (instr_out !== 16'hA5A5 || pc_plus2_out !== 16'h0002 || instr_valid !== 1'b1 || imem_addr !== 16'h0002) begin failures++; $display("FAIL hit_0 got=%h/%h/%b/%h exp=a5a5/0002/1/0002", instr_out, pc_plus2_out, instr_valid, imem_addr); end
        tick();
        checks++; if (instr_out !== 16'hA5A7 || pc_plus2_out !== 16'h0004 || instr_valid !== 1'b1 || imem_addr !== 16'h0004) begin failures++; $display("FAIL hit_2 got=%h/%h/%b/%h exp=a5a7/0004/1/0004", instr_out, pc_plus2_out, instr_valid, imem_addr); end
        tick();
        pipe_stall = 1'b1;
        checks++; if (instr_out !== 16'hA5A1 || pc_plus2_out !== 16'h0006 || instr_valid !== 1'b1) begin failures++; $display("FAIL hit_4 got=%h/%h/%b exp=a5a1/0006/1", instr_out, pc_plus2_out, instr_valid); end
    endtask

    task automatic test_miss;
        hit_mode = 1'b0; man_done = 1'b0;
        go_to(16'h0010);
        pipe_stall = 1'b0;
        #1;
        rd_cnt = int'(imem_rd);
        busy_cnt = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            man_done = (i == 3);
            man_data = 16'h1234;
            #1;
            busy_cnt += int'(fetch_busy);
            rd_cnt += int'(imem_rd);
            checks++; if (imem_addr !== 16'h0010) begin failures++; $display("FAIL miss_addr_hold got=%h exp=0010", imem_addr); end
            tick();
        end
        man_done = 1'b0;
        pipe_stall = 1'b1;
        checks++; if (rd_cnt !== 1) begin failures++; $display("FAIL miss_rd_pulses got=%0d exp=1", rd_cnt); end
        checks++; if (busy_cnt !== 4) begin failures++; $display("FAIL miss_busy_cycles got=%0d exp=4", busy_cnt); end
        checks++; if (instr_out !== 16'h1234 || pc_plus2_out !== 16'h0012 || instr_valid !== 1'b1 || fetch_busy !== 1'b0) begin failures++; $display("FAIL miss_result got=%h/%h/%b/%b exp=1234/0012/1/0", instr_out, pc_plus2_out, instr_valid, fetch_busy); end
    endtask

    task automatic test_redirect_in_miss;
        hit_mode = 1'b1;
        go_to(16'h001E);
        pipe_stall = 1'b0;
        tick();
        checks++; if (instr_out !== 16'hA5BB || instr_valid !== 1'b1 || imem_addr !== 16'h0020) begin failures++; $display("FAIL redir_prefetch got=%h/%b/%h exp=a5bb/1/0020", instr_out, instr_valid, imem_addr); end
        hit_mode = 1'b0; man_done = 1'b0;
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0 || fetch_busy !== 1'b1 || imem_addr !== 16'h0020) begin failures++; $display("FAIL redir_pending got=%b/%b/%h exp=0/1/0020", instr_valid, fetch_busy, imem_addr); end
        man_done = 1'b1; man_data = 16'hBEEF;
        #1;
        checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL redir_wait_rd got=%b exp=0", imem_rd); end
        tick();
        man_done = 1'b0;
        checks++; if (instr_valid !== 1'b0 || instr_out !== 16'h0800 || fetch_busy !== 1'b0) begin failures++; $display("FAIL redir_discard got=%b/%h/%b exp=0/0800/0", instr_valid, instr_out, fetch_busy); end
        #1;
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0100) begin failures++; $display("FAIL redir_target got=%b/%h exp=1/0100", imem_rd, imem_addr); end
        pipe_stall = 1'b1;
    endtask

    task automatic test_stall_hold;
        pipe_stall = 1'b0; man_done = 1'b0;
        tick();
        pipe_stall = 1'b1; man_done = 1'b1; man_data = 16'h4321;
        #1;
        rd_cnt = int'(imem_rd);
        tick();
        man_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            rd_cnt += int'(imem_rd);
            checks++; if (instr_valid !== 1'b0 || instr_out !== 16'h0800 || pc_plus2_out !== 16'h0020 || fetch_busy !== 1'b0) begin failures++; $display("FAIL hold_ir_kept got=%b/%h/%h/%b exp=0/0800/0020/0", instr_valid, instr_out, pc_plus2_out, fetch_busy); end
            tick();
        end
        pipe_stall = 1'b0;
        #1;
        rd_cnt += int'(imem_rd);
        tick();
        pipe_stall = 1'b1;
        checks++; if (rd_cnt !== 0) begin failures++; $display("FAIL hold_no_rd got=%0d exp=0", rd_cnt); end
        checks++; if (instr_out !== 16'h4321 || pc_plus2_out !== 16'h0102 || instr_valid !== 1'b1) begin failures++; $display("FAIL hold_release got=%h/%h/%b exp=4321/0102/1", instr_out, pc_plus2_out, instr_valid); end
    endtask

    task automatic test_halt;
        pipe_stall = 1'b0; man_done = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        man_done = 1'b1; man_data = 16'h5555;
        tick();
        man_done = 1'b0;
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || instr_out !== 16'h0800 || fetch_busy !== 1'b0) begin failures++; $display("FAIL halt_enter got=%b/%b/%h/%b exp=1/0/0800/0", halted, instr_valid, instr_out, fetch_busy); end
        hit_mode = 1'b1;
        rd_cnt = 0;
        halt_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            redirect = (i == 5);
            redirect_pc = 16'h0300;
            #1;
            rd_cnt += int'(imem_rd);
            tick();
            halt_cnt += int'(halted);
        end
        redirect = 1'b0;
        checks++; if (rd_cnt !== 0) begin failures++; $display("FAIL halt_no_rd got=%0d exp=0", rd_cnt); end
        checks++; if (halt_cnt !== 20) begin failures++; $display("FAIL halt_sticky got=%0d exp=20", halt_cnt); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (halted !== 1'b0 || imem_addr !== 16'h0000) begin failures++; $display("FAIL halt_reset got=%b/%h exp=0/0000", halted, imem_addr); end
        tick();
        #1;
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin failures++; $display("FAIL halt_resume_req got=%b/%h exp=1/0000", imem_rd, imem_addr); end
        tick();
        pipe_stall = 1'b1;
        checks++; if (instr_out !== 16'hA5A5 || instr_valid !== 1'b1 || pc_plus2_out !== 16'h0002) begin failures++; $display("FAIL halt_resume_ir got=%h/%b/%h exp=a5a5/1/0002", instr_out, instr_valid, pc_plus2_out); end
    endtask

    task automatic test_wrap_and_redirect_halt;
        hit_mode = 1'b1;
        go_to(16'hFFFE);
        pipe_stall = 1'b0;
        #1;
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_req got=%b/%h exp=1/fffe", imem_rd, imem_addr); end
        tick();
        checks++; if (instr_out !== 16'h5A5B || pc_plus2_out !== 16'h0000 || instr_valid !== 1'b1 || imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_ir got=%h/%h/%b/%h exp=5a5b/0000/1/0000", instr_out, pc_plus2_out, instr_valid, imem_addr); end
        redirect = 1'b1; redirect_pc = 16'h0200; halt = 1'b1;
        #1;
        checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL redir_halt_rd got=%b exp=0", imem_rd); end
        tick();
        redirect = 1'b0; halt = 1'b0;
        checks++; if (halted !== 1'b0 || imem_addr !== 16'h0200 || instr_valid !== 1'b0 || instr_out !== 16'h0800) begin failures++; $display("FAIL redir_halt_take got=%b/%h/%b/%h exp=0/0200/0/0800", halted, imem_addr, instr_valid, instr_out); end
        tick();
        pipe_stall = 1'b1;
        checks++; if (instr_out !== 16'hA7A5 || pc_plus2_out !== 16'h0202 || instr_valid !== 1'b1) begin failures++; $display("FAIL redir_halt_fetch got=%h/%h/%b exp=a7a5/0202/1", instr_out, pc_plus2_out, instr_valid); end
    endtask

    initial begin
        repeat (2) tick();
        test_reset_and_hits();
        test_miss();
        test_redirect_in_miss();
        test_stall_hold();
        test_halt();
        test_wrap_and_redirect_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
